cordic_fp_seq: RTL and testbench

CORDIC_FP_SEQ -- requirements
Module: cordic_fp_seq

---
 rtl/cordic_pkg.sv | 28 ++
 rtl/fp32_addsub.sv | 69 ++++++
 rtl/fp_scale_pow2.sv | 16 +
 rtl/cordic_fp_seq.sv | 151 +++++++++++++++
 tb/tb_cordic_fp_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the sequential FP32 CORDIC.
// Angle table holds atan(2^-i) as FP32 bit patterns.
package cordic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC_X,
    S_CALC_Y,
    S_CALC_Z,
    S_DONE
  } state_t;

  localparam int N_ITER_MAX = 16;

  localparam logic [31:0] K_INV = 32'h3F1B74EE;

  localparam logic [31:0] ATAN_TAB [N_ITER_MAX] = '{
    32'h3F490FDB, 32'h3EED6338,
    32'h3E7ADBB0, 32'h3DFEADD5,
    32'h3D7FAADE, 32'h3CFFEAAE,
    32'h3C7FFAAB, 32'h3BFFFEAB,
    32'h3B7FFFAB, 32'h3AFFFFEB,
    32'h3A7FFFFB, 32'h39FFFFFF,
    32'h39800000, 32'h39000000,
    32'h38800000, 32'h38000000
  };

endpackage

// File: rtl/fp32_addsub.sv
// Combinational FP32 adder/subtractor (sub=1 gives a-b).
// Subnormals flush to zero; result mantissa is truncated.
module fp32_addsub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);

  logic        sa;
  logic        sb;
  logic        s_big;
  logic        a_big;
  logic        eff_sub;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [7:0]  e_big;
  logic [7:0]  e_sml;
  logic [7:0]  ediff;
  logic [7:0]  e_res;
  logic [26:0] ma;
  logic [26:0] mb;
  logic [26:0] m_big;
  logic [26:0] m_sml;
  logic [26:0] m_shf;
  logic [26:0] norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic        unused_ok;

  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ sub;
    ea    = a[30:23];
    eb    = b[30:23];
    ma    = (ea == 8'd0) ? '0 : {1'b1, a[22:0], 3'b000};
    mb    = (eb == 8'd0) ? '0 : {1'b1, b[22:0], 3'b000};
    a_big = {ea, a[22:0]} >= {eb, b[22:0]};
    s_big = a_big ? sa : sb;
    e_big = a_big ? ea : eb;
    e_sml = a_big ? eb : ea;
    m_big = a_big ? ma : mb;
    m_sml = a_big ? mb : ma;
    ediff = e_big - e_sml;
    m_shf = (ediff > 8'd26) ? '0 : (m_sml >> ediff);
    eff_sub = sa ^ sb;
    sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_shf})
                  : ({1'b0, m_big} + {1'b0, m_shf});
    lz = '0;
    for (int k = 0; k <= 26; k++) begin
      if (sum[k]) lz = 5'(26 - k);
    end
    norm  = sum[26:0] << lz;
    e_res = '0;
    y     = '0;
    if (m_big == '0 || sum == '0) begin
      y = '0;
    end else if (sum[27]) begin
      e_res = e_big + 8'd1;
      y     = {s_big, e_res, sum[26:4]};
    end else if ({3'b000, lz} < e_big) begin
      e_res = e_big - {3'b000, lz};
      y     = {s_big, e_res, norm[25:3]};
    end
  end

  assign unused_ok = ^{norm[26], norm[2:0], sum[3:0]};

endmodule

// File: rtl/fp_scale_pow2.sv
// Divide an FP32 value by 2^sh by adjusting the exponent only.
// Results that would underflow to a subnormal collapse to +0.
module fp_scale_pow2 (
  input  logic [31:0] v,
  input  logic [3:0]  sh,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    if (v[30:23] > {4'b0000, sh}) begin
      y = {v[31], v[30:23] - {4'b0000, sh}, v[22:0]};
    end
  end

endmodule

// File: rtl/cordic_fp_seq.sv
// Sequential rotation-mode CORDIC producing FP32 cos/sin.
// One shared FP adder is time-multiplexed over x, y and z.
module cordic_fp_seq
  import cordic_pkg::*;
#(
  parameter int N_ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out
);

  localparam logic [3:0] LAST = 4'(N_ITER - 1);

  state_t      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] z_q, z_d;
  logic [31:0] xt_q, xt_d;
  logic [31:0] cos_q, cos_d;
  logic [31:0] sin_q, sin_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [31:0] fa;
  logic [31:0] fb;
  logic        fctl;
  logic [31:0] fres;
  logic [31:0] y_scl;
  logic [31:0] x_scl;

  fp_scale_pow2 u_scl_y (
    .v  (y_q),
    .sh (i_q),
    .y  (y_scl)
  );

  fp_scale_pow2 u_scl_x (
    .v  (x_q),
    .sh (i_q),
    .y  (x_scl)
  );

  fp32_addsub u_fpu (
    .a   (fa),
    .b   (fb),
    .sub (fctl),
    .y   (fres)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xt_d    = xt_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    done_d  = 1'b0;
    fa      = '0;
    fb      = '0;
    fctl    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = K_INV;
          y_d     = '0;
          z_d     = angle;
          i_d     = '0;
          state_d = S_CALC_X;
        end
      end
      S_CALC_X: begin
        fa      = x_q;
        fb      = y_scl;
        fctl    = ~z_q[31];
        xt_d    = fres;
        state_d = S_CALC_Y;
      end
      S_CALC_Y: begin
        fa      = y_q;
        fb      = x_scl;
        fctl    = z_q[31];
        y_d     = fres;
        x_d     = xt_q;
        state_d = S_CALC_Z;
      end
      S_CALC_Z: begin
        fa   = z_q;
        fb   = ATAN_TAB[i_q];
        fctl = ~z_q[31];
        z_d  = fres;
        i_d  = i_q + 4'd1;
        if (i_q == LAST) begin
          state_d = S_DONE;
          cos_d   = x_q;
          sin_d   = y_q;
          done_d  = 1'b1;
        end else begin
          state_d = S_CALC_X;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xt_q    <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xt_q    <= xt_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_fp_seq.sv
// Bench for cordic_fp_seq: directed and random angles
// checked against real-valued $cos/$sin.
module tb_cordic_fp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] angle = '0;
  logic        busy;
  logic        done;
  logic [31:0] cos_out;
  logic [31:0] sin_out;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int done_edge;
  int done_abs;
  int n_done;

  cordic_fp_seq #(.N_ITER(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .angle   (angle),
    .busy    (busy),
    .done    (done),
    .cos_out (cos_out),
    .sin_out (sin_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  function automatic real fp2real(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(int'({9'd0, f[22:0]})) / 8388608.0;
    e = int'({24'd0, f[30:23]}) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real2fp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    return {d[63], 8'(int'({21'd0, d[62:52]}) - 896), d[51:29]};
  endfunction

  function automatic logic near(input real o, input real e);
    return ((o - e) < 2.0e-4) && ((e - o) < 2.0e-4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs,
                          input real exp);
    real o;
    o = fp2real(obs);
    tests++;
    assert (near(o, exp) === 1'b1) else begin
      fails++;
      $error("FAIL %s: got %f expected %f", tag, o, exp);
    end
  endtask

  task automatic chk_trig(input string tag, input logic [31:0] a);
    real ar;
    ar = fp2real(a);
    chk_near({tag, "_cos"}, cos_out, $cos(ar));
    chk_near({tag, "_sin"}, sin_out, $sin(ar));
  endtask

  // Start one conversion, optionally re-pulse start at edges ra/rb,
  // and return one edge after done (edge 1 = accept edge).
  task automatic run_conv(input string tag, input logic [31:0] a,
                          input int ra, input int rb);
    int n;
    int hold_err;
    int busy_err;
    logic [31:0] hc;
    logic [31:0] hs;
    hc = cos_out;
    hs = sin_out;
    hold_err = 0;
    busy_err = 0;
    done_edge = 0;
    n_done = 0;
    angle = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    if (!busy) busy_err++;
    while (n < 60 && !(done_edge != 0 && n > done_edge)) begin
      start = (n + 1 == ra) || (n + 1 == rb);
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        n_done++;
        if (done_edge == 0) begin
          done_edge = n;
          done_abs = edge_cnt;
        end
      end
      if (done_edge == 0 || n == done_edge) begin
        if (!busy) busy_err++;
      end
      if (done_edge == 0) begin
        if (cos_out !== hc || sin_out !== hs) hold_err++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_edge"}, 32'(done_edge), 32'd49);
    chk({tag, "_n_done"}, 32'(n_done), 32'd1);
    chk({tag, "_busy_run"}, 32'(busy_err), 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, 32'(hold_err), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] c1;
    logic [31:0] s1;
    int d1;
    int bad;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cos", cos_out, 32'h0);
    chk("rst_sin", sin_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv("zero", 32'h00000000, 0, 0);
    chk_near("zero_cos", cos_out, 1.0);
    chk_near("zero_sin", sin_out, 0.0);

    run_conv("negzero", 32'h80000000, 0, 0);
    chk_trig("negzero", 32'h80000000);

    run_conv("pi6", 32'h3F060A92, 0, 0);
    chk_near("pi6_cos", cos_out, 0.86603);
    chk_near("pi6_sin", sin_out, 0.50000);

    run_conv("mpi4", 32'hBF490FDB, 0, 0);
    chk_near("mpi4_cos", cos_out, 0.70711);
    chk_near("mpi4_sin", sin_out, -0.70711);
    chk("mpi4_sign", {31'd0, sin_out[31]}, 32'd1);

    a = real2fp(1.2);
    run_conv("repulse", a, 5, 48);
    chk_trig("repulse", a);

    angle = 32'h3F060A92;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_cos", cos_out, 32'h0);
    chk("abort_sin", sin_out, 32'h0);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || busy) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("after_rst", 32'h3F060A92, 0, 0);
    chk_near("after_rst_cos", cos_out, 0.86603);
    chk_near("after_rst_sin", sin_out, 0.50000);

    a = real2fp(-0.9);
    run_conv("b2b_1", a, 0, 0);
    chk_trig("b2b_1", a);
    d1 = done_abs;
    c1 = cos_out;
    s1 = sin_out;
    a = real2fp(0.4);
    run_conv("b2b_2", a, 0, 0);
    chk_trig("b2b_2", a);
    chk("b2b_gap", 32'(done_abs - d1), 32'd50);
    tests++;
    assert ((cos_out !== c1) === 1'b1) else begin
      fails++;
      $error("FAIL b2b_update: got %h expected change from %h",
             cos_out, c1);
    end

    for (int k = 0; k < 6; k++) begin
      real r;
      r = (real'($urandom_range(30000, 0)) - 15000.0) / 10000.0;
      a = real2fp(r);
      run_conv("rand", a, 0, 0);
      chk_trig("rand", a);
    end

    run_conv("range_hi", real2fp(3.0), 0, 0);
    run_conv("range_lo", real2fp(-2.5), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
